// File: rtl/seg_adder_pipe.sv
//==============================================================================
// Module      : seg_adder_pipe
// Description : Segmented, carry-staggered wide adder/subtractor. Two
//               LANES*LANE_W-bit operands are split into independent segments
//               of 2^k lanes (k chosen per beat). Stage 0 forms per-lane sums;
//               stage s then resolves the carry into lane s. Full valid/ready
//               backpressure; latency LANES cycles, one beat per cycle.
// Ports       : clk_i, rst_n_i (sync, active-low)
//               valid_i/ready_o  - input handshake
//               a_i, b_i, sub_i, seg_log2_i - operands and per-beat mode
//               valid_o/ready_i  - output handshake
//               sum_o            - segmented result
//               cout_o           - per-segment carry-out (ADDER_COUT_EN only)
// Options     : `define ADDER_COUT_EN to expose cout_o.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg_adder_pipe #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int SEG_W  = $clog2(LANES) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [LANES*LANE_W-1:0]   a_i,
    input  logic [LANES*LANE_W-1:0]   b_i,
    input  logic                      sub_i,
    input  logic [SEG_W-1:0]          seg_log2_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [LANES*LANE_W-1:0]   sum_o
`ifdef ADDER_COUT_EN
    ,
    output logic [LANES-1:0]          cout_o
`endif
);

    localparam int LG = $clog2(LANES);

    // Lane j starts a segment of 2^k lanes when its low k index bits are zero.
    function automatic logic lane_is_base(input logic [SEG_W-1:0] k, input int j);
        int m;
        m = (1 << k) - 1;
        return (j & m) == 0;
    endfunction

    // Pipeline state, one entry per stage
    logic [LANES*LANE_W-1:0] r_val [LANES];
    logic [LANES-1:0]        r_cy  [LANES];
    logic [SEG_W-1:0]        r_k   [LANES];
    logic [LANES-1:0]        r_vld;

    // Next-state values for each stage
    logic [LANES*LANE_W-1:0] w_val [LANES];
    logic [LANES-1:0]        w_cy  [LANES];
    logic [SEG_W-1:0]        w_k_in;
    logic [LANE_W-1:0]       w_bp;
    logic                    w_cin;
    logic [LANE_W:0]         w_t;
    logic                    w_adv;

    // Oversized segment requests collapse to one full-width segment
    assign w_k_in  = (seg_log2_i > SEG_W'(LG)) ? SEG_W'(LG) : seg_log2_i;

    assign valid_o = r_vld[LANES-1];
    assign ready_o = ready_i | ~valid_o;
    assign w_adv   = ready_o;
    assign sum_o   = r_val[LANES-1];

    always_comb begin
        w_bp  = '0;
        w_cin = 1'b0;
        w_t   = '0;
        for (int s = 0; s < LANES; s++) begin
            w_val[s] = '0;
            w_cy[s]  = '0;
        end

        // Stage 0: independent per-lane add; subtraction injects the +1 of
        // the two's complement only at each segment base.
        for (int j = 0; j < LANES; j++) begin
            w_bp  = sub_i ? ~b_i[j*LANE_W +: LANE_W] : b_i[j*LANE_W +: LANE_W];
            w_cin = sub_i & lane_is_base(w_k_in, j);
            w_t   = {1'b0, a_i[j*LANE_W +: LANE_W]} + {1'b0, w_bp}
                  + {{LANE_W{1'b0}}, w_cin};
            w_val[0][j*LANE_W +: LANE_W] = w_t[LANE_W-1:0];
            w_cy[0][j]                   = w_t[LANE_W];
        end

        // Stage s: lane s-1 is final, so fold its carry into lane s unless
        // lane s opens a new segment (carry must not cross segments).
        for (int s = 1; s < LANES; s++) begin
            w_val[s] = r_val[s-1];
            w_cy[s]  = r_cy[s-1];
            if (!lane_is_base(r_k[s-1], s)) begin
                w_t = {1'b0, r_val[s-1][s*LANE_W +: LANE_W]}
                    + {{LANE_W{1'b0}}, r_cy[s-1][s-1]};
                w_val[s][s*LANE_W +: LANE_W] = w_t[LANE_W-1:0];
                w_cy[s][s]                   = r_cy[s-1][s] | w_t[LANE_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_vld <= '0;
            for (int s = 0; s < LANES; s++) begin
                r_val[s] <= '0;
                r_cy[s]  <= '0;
                r_k[s]   <= '0;
            end
        end else if (w_adv) begin
            r_vld    <= {r_vld[LANES-2:0], valid_i};
            r_k[0]   <= w_k_in;
            r_val[0] <= w_val[0];
            r_cy[0]  <= w_cy[0];
            for (int s = 1; s < LANES; s++) begin
                r_k[s]   <= r_k[s-1];
                r_val[s] <= w_val[s];
                r_cy[s]  <= w_cy[s];
            end
        end
    end

`ifdef ADDER_COUT_EN
    // Only the top lane of each segment reports its carry
    always_comb begin
        cout_o = '0;
        for (int j = 0; j < LANES; j++) begin
            if (lane_is_base(r_k[LANES-1], j + 1)) begin
                cout_o[j] = r_cy[LANES-1][j];
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/seg_adder_pipe.md
Name: seg_adder_pipe

Overview:
- Parametrised successor to the fixed 8x32-bit carry-staggered adder tree.
- Adds or subtracts two LANES*LANE_W-bit operands, split into independent segments of 2^k lanes; k is chosen per beat.
- Carry resolves one lane per pipeline stage, with full valid/ready backpressure.
- Sits between the PRNG share/correction sources and the correlated-output formatter.

Parameters:
- LANES, 8, number of lanes; power of two, 2..16.
- LANE_W, 32, bits per lane.
- SEG_W, $clog2(LANES)+1, width of seg_log2_i.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat
- a_i  in  LANES*LANE_W  operand A; lane j = bits [j*LANE_W +: LANE_W]
- b_i  in  LANES*LANE_W  operand B
- sub_i  in  1  1: compute A-B per segment; 0: compute A+B
- seg_log2_i  in  SEG_W  segment size = 2^seg_log2_i lanes
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts
- sum_o  out  LANES*LANE_W  result, modulo 2^(segment width) per segment
- cout_o  out  LANES  carry-out; bit j is meaningful only at the top lane of a segment, otherwise 0 (ADDER_COUT_EN only)

Behaviour:
- Segment rules:
  - Effective k = min(seg_log2_i, log2(LANES)); values above the maximum clamp to a single full-width segment.
  - Lane j is a segment base when j mod 2^k == 0.
  - sub_i and k are captured with the beat and travel down the pipeline, so mode may change on every beat.
- Stage 0 (per lane):
  - B' = sub ? ~B : B.
  - Carry-in = sub AND lane is a segment base.
  - Register {carry_j, val_j} = A_j + B'_j + cin_j, LANE_W+1 bits.
- Stage s, 1..LANES-1:
  - Only lane s changes: if lane s is not a segment base, val_s += carry_{s-1}; otherwise val_s is unchanged.
  - carry_s becomes (old carry_s) OR (carry from this increment).
  - All other lanes pass through unchanged.
- Output and latency:
  - The stage LANES-1 register drives sum_o.
  - Latency is exactly LANES cycles from accept (valid_i & ready_o) to valid_o, when there is no stall.
  - Throughput is one beat per cycle.
- Handshake:
  - ready_o = ready_i | ~valid_o.
  - All stages, including valid bits, advance only when ready_o = 1; otherwise every stage holds.
  - Internal bubbles are not compressed.
  - While valid_o & ~ready_i, sum_o, cout_o and valid_o hold stable.
  - A beat presented while ready_o = 0 is not captured; the source must hold it.
- Reset (rst_n_i = 0 at a clock edge):
  - All stage valids, values, carries and modes clear to 0, so valid_o = 0, sum_o = 0, cout_o = 0, and ready_o = 1 the next cycle.
  - In-flight beats are dropped.
  - Reset takes priority over the advance.
- Boundary cases:
  - With k = 0 every lane is independent, and stages 1..LANES-1 are pass-through for data while still contributing latency.
  - A carry out of a segment's top lane never enters the next segment.
  - Subtraction underflow wraps modulo 2^(segment width).

Optional Feature:
- Macro: ADDER_COUT_EN.
- Defined:
  - cout_o is present.
  - Bit j = final carry_j if lane j is the top lane of its segment (j mod 2^k == 2^k-1), else 0.
  - For subtraction, cout = 1 means no borrow (A >= B).
- Undefined:
  - cout_o port is absent.
  - Carry flags exist only as internal stage state; the final-lane carry register may be optimised away.
  - Sum behaviour is identical.

Test Plan:
Defaults are LANES=8, LANE_W=32.
1. Full-width add: A=2^256-1, B=1, seg_log2=3, add, ready_i=1.
   -> 8 cycles later sum_o=0, cout_o=8'h80.
2. Per-lane add: same operands, seg_log2=0.
   -> lane0=0, lanes1..7=0xFFFFFFFF; cout_o=8'h01.
3. 64-bit subtract: lane pair (1,0) A=5, B=7, seg_log2=1, sub=1.
   -> lanes 1:0 = 0xFFFFFFFF_FFFFFFFE; cout_o[1]=0.
   -> A=7, B=5 in lanes 3:2 in the same beat gives 2 and cout_o[3]=1.
4. Backpressure: stream 10 beats with ready_i low on cycles 9-12 and on every third cycle afterwards.
   -> All 10 results appear in order with correct values; outputs stay stable while stalled.
   -> ready_o=0 exactly when valid_o & ~ready_i.
5. Mixed modes back-to-back: alternate beats of seg_log2=2 add and seg_log2=3 sub with 128-bit carry-crossing operands (lane3=0xFFFFFFFF, lane4=0).
   -> The carry does not cross lane3->4 in 128-bit mode, and does in 256-bit mode.
6. Reset mid-flight: accept 4 beats, assert rst_n_i low for 1 cycle at cycle 3.
   -> valid_o never asserts for those beats; sum_o=0; ready_o=1 the cycle after reset.
   -> The next accepted beat emerges after exactly 8 cycles.
